// File: rtl/md_unit_if.sv
// Decoder/hazard-side bundle for the multiply/divide unit: strobes and operands in,
// busy and the HI/LO registers out.
interface md_unit_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_write;
  logic        lo_write;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b, hi_write, lo_write, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, hi_write, lo_write, req,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO: the result is computed at accept, held in a
// shadow pair and committed after a fixed busy interval so the pipeline sees MIPS-like latency.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   sh_hi, sh_lo;
  logic          sh_valid;
  logic          accept, done, mt_ok;

  // Datapath signals
  logic          is_signed, is_div, div_zero;
  logic [63:0]   ext_a, ext_b, prod;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, den, q_mag, r_mag, quot, rem;
  logic [31:0]   res_hi, res_lo;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.req) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // start wins over a simultaneous mthi/mtlo
  assign mt_ok = (state == IDLE) && !bus.req && !bus.start;

  // Sign-extending the operands lets one unsigned 64-bit multiplier serve both mult and multu.
  always_comb begin
    is_signed = ~bus.md_op[0];
    is_div    = bus.md_op[1];
    div_zero  = is_div && (bus.b == '0);
    ext_a     = {{32{is_signed & bus.a[31]}}, bus.a};
    ext_b     = {{32{is_signed & bus.b[31]}}, bus.b};
    prod      = ext_a * ext_b;

    a_neg     = is_signed & bus.a[31];
    b_neg     = is_signed & bus.b[31];
    a_mag     = a_neg ? (~bus.a + 32'd1) : bus.a;
    b_mag     = b_neg ? (~bus.b + 32'd1) : bus.b;
    den       = (bus.b == '0) ? 32'd1 : b_mag;
    q_mag     = a_mag / den;
    r_mag     = a_mag % den;
    quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem       = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_hi    = is_div ? rem  : prod[63:32];
    res_lo    = is_div ? quot : prod[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      sh_hi    <= '0;
      sh_lo    <= '0;
      sh_valid <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        cnt      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        sh_hi    <= res_hi;
        sh_lo    <= res_lo;
        sh_valid <= ~div_zero;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end

      if (done) begin
        if (sh_valid) begin
          hi_q <= sh_hi;
          lo_q <= sh_lo;
        end
      end else if (mt_ok) begin
        if (bus.hi_write) hi_q <= bus.a;
        if (bus.lo_write) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed corner cases followed by randomized operations checked
// against an arithmetic HI/LO model.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'd0: begin
        q = sx * sy;
        mhi = q[63:32];
        mlo = q[31:0];
      end
      2'd1: begin
        pu = longint'({32'b0, x}) * longint'({32'b0, y});
        mhi = pu[63:32];
        mlo = pu[31:0];
      end
      2'd2: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        mlo = q[31:0];
        mhi = r[31:0];
      end
      default: if (y != 0) begin
        mlo = x / y;
        mhi = x % y;
      end
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.md_op = 2'd0; bus.a = '0; bus.b = '0;
    bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.hi, mhi);
    check({tag, "_lo"}, bus.lo, mlo);
  endtask

  // inj: RUN cycle (1..n) at which stray start/mthi/mtlo are driven; 0 means none.
  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int unsigned inj, input bit req_noise, input bit also_write);
    int unsigned n;
    logic [31:0] old_hi, old_lo;
    n = op[1] ? DC : MC;
    old_hi = mhi;
    old_lo = mlo;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.a = x; bus.b = y;
    bus.hi_write = also_write; bus.lo_write = also_write;
    model_op(op, x, y);
    @(posedge clk);
    for (int k = 1; k <= int'(n); k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
      bus.req = req_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      check("run_busy", {31'b0, bus.busy}, 32'd1);
      check("run_hi_hold", bus.hi, old_hi);
      check("run_lo_hold", bus.lo, old_lo);
      if (k == int'(inj)) begin
        bus.start = 1'b1; bus.md_op = 2'($urandom_range(0, 3));
        bus.a = $urandom; bus.b = $urandom;
        bus.hi_write = 1'b1; bus.lo_write = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    check_idle("done");
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] x, input bit rq);
    @(negedge clk);
    bus.a = x; bus.hi_write = to_hi; bus.lo_write = !to_hi; bus.req = rq;
    if (!rq) begin
      if (to_hi) mhi = x;
      else       mlo = x;
    end
    @(negedge clk);
    idle_inputs();
    check_idle(rq ? "mt_blocked" : "mt");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] x, y;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b0);
    check("t1_hi", bus.hi, 32'hFFFF_FFFF);
    check("t1_lo", bus.lo, 32'hFFFF_FFFA);

    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b0);
    check("t2_hi", bus.hi, 32'h0000_0001);
    check("t2_lo", bus.lo, 32'hFFFF_FFFE);

    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    check("t3_hi", bus.hi, 32'hFFFF_FFFF);
    check("t3_lo", bus.lo, 32'hFFFF_FFFD);

    mt(1'b1, 32'h11, 1'b0);
    mt(1'b0, 32'h22, 1'b0);
    run_op(2'd3, 32'd7, 32'd0, 0, 1'b0, 1'b0);
    check("divz_hi", bus.hi, 32'h11);
    check("divz_lo", bus.lo, 32'h22);

    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    check("ovf_hi", bus.hi, 32'h0);
    check("ovf_lo", bus.lo, 32'h8000_0000);

    run_op(2'd2, 32'd100, 32'hFFFF_FFF9, 3, 1'b1, 1'b0);
    check("t4_hi", bus.hi, 32'd2);
    check("t4_lo", bus.lo, 32'hFFFF_FFF2);

    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 2'd0; bus.a = 32'd9; bus.b = 32'd9; bus.req = 1'b1;
    @(negedge clk);
    idle_inputs();
    check_idle("req_start");
    mt(1'b0, 32'h1234, 1'b1);
    mt(1'b0, 32'h1234, 1'b0);
    check("t5_lo", bus.lo, 32'h1234);

    run_op(2'd1, 32'd6, 32'd7, MC, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        x = 32'($signed(16'($urandom)));
        y = 32'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 4) == 0)
        mt(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      run_op(op, x, y, $urandom_range(0, op[1] ? DC : MC),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    mt(1'b1, 32'hA5A5_0001, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 2'd0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check("rst_pre_busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mhi = '0;
    mlo = '0;
    check_idle("rst_abort");
    for (int k = 0; k < int'(MC) + 3; k++) begin
      @(negedge clk);
      check_idle("rst_after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
